// File: rtl/seq_multiplier_n.sv
// Iterative shift-add multiplier: one partial product per clock, signed/unsigned
// mode, valid/ready handshakes on both the operand and the product side.
module seq_multiplier_n #(
    parameter int unsigned WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 is_signed,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product,
    output logic                 busy
);

    localparam int unsigned CNT_W = $clog2(WIDTH) + 1;
    localparam int unsigned PW    = 2 * WIDTH;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state,     w_state;
    logic [CNT_W-1:0]   r_cnt,       w_cnt;
    logic [WIDTH-1:0]   r_mcand,     w_mcand;
    logic [WIDTH-1:0]   r_mplier,    w_mplier;
    logic [WIDTH-1:0]   r_acc,       w_acc;
    logic               r_neg,       w_neg;
    logic               r_in_ready,  w_in_ready;
    logic               r_out_valid, w_out_valid;
    logic               r_busy,      w_busy;
    logic [PW-1:0]      r_product,   w_product;

    // One iteration: conditional add into the upper half, then shift {carry, acc, mplier} right.
    logic [WIDTH:0]     w_sum;
    logic [WIDTH-1:0]   w_step_acc;
    logic [WIDTH-1:0]   w_step_mpl;
    logic [PW-1:0]      w_raw;

    assign w_sum      = {1'b0, r_acc} + (r_mplier[0] ? {1'b0, r_mcand} : '0);
    assign w_step_acc = w_sum[WIDTH:1];
    assign w_step_mpl = {w_sum[0], r_mplier[WIDTH-1:1]};
    assign w_raw      = {w_step_acc, w_step_mpl};

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign busy      = r_busy;
    assign product   = r_product;

    // Next-state and next-register logic
    always_comb begin
        w_state     = r_state;
        w_cnt       = r_cnt;
        w_mcand     = r_mcand;
        w_mplier    = r_mplier;
        w_acc       = r_acc;
        w_neg       = r_neg;
        w_in_ready  = r_in_ready;
        w_out_valid = r_out_valid;
        w_busy      = r_busy;
        w_product   = r_product;

        case (r_state)
            S_IDLE: begin
                if (in_valid) begin
                    // Magnitude of the most-negative value still fits in WIDTH unsigned bits.
                    w_mcand    = (is_signed && a[WIDTH-1]) ? WIDTH'(-a) : a;
                    w_mplier   = (is_signed && b[WIDTH-1]) ? WIDTH'(-b) : b;
                    w_neg      = is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
                    w_acc      = '0;
                    w_cnt      = '0;
                    w_in_ready = 1'b0;
                    w_busy     = 1'b1;
                    w_state    = S_CALC;
                end
            end
            S_CALC: begin
                w_acc    = w_step_acc;
                w_mplier = w_step_mpl;
                w_cnt    = r_cnt + CNT_W'(1);
                if (r_cnt == CNT_W'(WIDTH - 1)) begin
                    w_product   = r_neg ? PW'(-w_raw) : w_raw;
                    w_out_valid = 1'b1;
                    w_state     = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    w_out_valid = 1'b0;
                    w_in_ready  = 1'b1;
                    w_busy      = 1'b0;
                    w_state     = S_IDLE;
                end
            end
            default: begin
                w_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_mcand     <= '0;
            r_mplier    <= '0;
            r_acc       <= '0;
            r_neg       <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_product   <= '0;
        end else begin
            r_state     <= w_state;
            r_cnt       <= w_cnt;
            r_mcand     <= w_mcand;
            r_mplier    <= w_mplier;
            r_acc       <= w_acc;
            r_neg       <= w_neg;
            r_in_ready  <= w_in_ready;
            r_out_valid <= w_out_valid;
            r_busy      <= w_busy;
            r_product   <= w_product;
        end
    end

endmodule

// File: tb/tb_seq_multiplier_n.sv
// Bench for seq_multiplier_n: directed WIDTH=32 cases with literal products, then a
// WIDTH=8 random regression checked every cycle against a queue-based arithmetic model.
module tb_seq_multiplier_n;

    logic        clk;
    logic        rst_n;
    logic        in_valid, in_ready, is_signed, out_valid, out_ready, busy;
    logic [31:0] a, b;
    logic [63:0] product;

    logic        rst8_n;
    logic        in_valid8, in_ready8, s8, out_valid8, out_ready8, busy8;
    logic [7:0]  a8, b8;
    logic [15:0] product8;

    int checks   = 0;
    int failures = 0;

    seq_multiplier_n #(.WIDTH(32)) u_dut32 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .is_signed(is_signed), .out_valid(out_valid),
        .out_ready(out_ready), .product(product), .busy(busy)
    );

    seq_multiplier_n #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst_n(rst8_n), .in_valid(in_valid8), .in_ready(in_ready8),
        .a(a8), .b(b8), .is_signed(s8), .out_valid(out_valid8),
        .out_ready(out_ready8), .product(product8), .busy(busy8)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // Reference product: plain integer arithmetic on the operands as the mode interprets them.
    function automatic logic [15:0] model8(input logic [7:0] x, input logic [7:0] y, input logic s);
        int sx, sy, p;
        sx = s ? int'($signed(x)) : int'(x);
        sy = s ? int'($signed(y)) : int'(y);
        p  = sx * sy;
        return p[15:0];
    endfunction

    function automatic logic [7:0] pick8();
        case ($urandom_range(0, 5))
            0:       return 8'h00;
            1:       return 8'h80;
            2:       return 8'hFF;
            3:       return 8'h7F;
            default: return 8'($urandom);
        endcase
    endfunction

    // One WIDTH=32 operation; operands are scrambled after acceptance to show they are not resampled.
    task automatic op32(input logic [31:0] ta, input logic [31:0] tb, input logic ts,
                        input logic [63:0] exp, input int stall, input string nm);
        int n;
        n = 0;
        while (!in_ready && n < 100) begin
            @(posedge clk); #1; n++;
        end
        check({nm, "_ready_before"}, 64'(in_ready), 64'd1);
        a = ta; b = tb; is_signed = ts; in_valid = 1'b1;
        out_ready = (stall == 0);
        @(posedge clk); #1;
        in_valid = 1'b0; a = $urandom; b = $urandom; is_signed = ~ts;
        check({nm, "_busy"}, 64'({busy, in_ready}), 64'b10);
        n = 0;
        while (!out_valid && n < 100) begin
            @(posedge clk); #1; n++;
            a = $urandom; b = $urandom;
        end
        check({nm, "_latency"}, 64'(n), 64'd32);
        check({nm, "_product"}, product, exp);
        for (int i = 0; i < stall; i++) begin
            @(posedge clk); #1;
            check({nm, "_stall"}, {61'd0, out_valid, in_ready, busy}, {61'd0, 3'b101});
            check({nm, "_stall_prod"}, product, exp);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        check({nm, "_after_hs"}, {61'd0, out_valid, in_ready, busy}, {61'd0, 3'b010});
        check({nm, "_kept_prod"}, product, exp);
        out_ready = 1'b0;
    endtask

    // WIDTH=8 scoreboard: expected products and their accept-edge cycle numbers.
    logic [15:0] q8_exp[$];
    int          q8_cyc[$];
    int          cyc8   = 0;
    int          acc8   = 0;
    int          pops8  = 0;

    always @(posedge clk) cyc8 <= cyc8 + 1;

    always @(negedge clk) begin
        logic exp_ov;
        if (!rst8_n) begin
            q8_exp.delete();
            q8_cyc.delete();
        end else begin
            exp_ov = 1'b0;
            if (q8_exp.size() != 0) exp_ov = (cyc8 >= q8_cyc[0] + 8);
            check("u8_in_ready", 64'(in_ready8), 64'(q8_exp.size() == 0));
            check("u8_busy", 64'(busy8), 64'(q8_exp.size() != 0));
            check("u8_out_valid", 64'(out_valid8), 64'(exp_ov));
            if (exp_ov) begin
                check("u8_product", 64'(product8), 64'(q8_exp[0]));
                if (out_valid8 && out_ready8) begin
                    void'(q8_exp.pop_front());
                    void'(q8_cyc.pop_front());
                    pops8++;
                end
            end
            if (in_valid8 && in_ready8) begin
                q8_exp.push_back(model8(a8, b8, s8));
                q8_cyc.push_back(cyc8 + 1);
                acc8++;
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        rst_n = 1'b0; rst8_n = 1'b0;
        in_valid = 1'b0; a = '0; b = '0; is_signed = 1'b0; out_ready = 1'b0;
        in_valid8 = 1'b0; a8 = '0; b8 = '0; s8 = 1'b0; out_ready8 = 1'b0;
        #12;
        check("reset_state", {busy, out_valid, in_ready, product}, {3'b001, 64'd0});
        @(negedge clk);
        rst_n = 1'b1; rst8_n = 1'b1;
        @(posedge clk); #1;

        // Model pinned against hand-computed products.
        check("model_s_m3x7", 64'(model8(8'hFD, 8'h07, 1'b1)), 64'h0000_0000_0000_FFEB);
        check("model_u_ffxff", 64'(model8(8'hFF, 8'hFF, 1'b0)), 64'h0000_0000_0000_FE01);
        check("model_s_min2", 64'(model8(8'h80, 8'h80, 1'b1)), 64'h0000_0000_0000_4000);

        op32(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001, 0, "u_max");
        op32(32'hFFFF_FFFD, 32'd7,         1'b1, 64'hFFFF_FFFF_FFFF_FFEB, 0, "s_m3x7");
        op32(32'hFFFF_FFFD, 32'd7,         1'b0, 64'h0000_0006_FFFF_FFEB, 0, "u_m3x7");
        op32(32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000, 0, "s_min2");
        op32(32'd0,         32'hFFFF_FFFB, 1'b1, 64'd0,                   0, "s_zero");
        op32(32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 64'h0B00_EA4E_242D_2080, 10, "bp");

        // Reset in the middle of CALC (counter at 15).
        a = 32'd123; b = 32'd456; is_signed = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (15) begin @(posedge clk); #1; end
        #2 rst_n = 1'b0;
        #1;
        check("mid_reset", {busy, out_valid, in_ready, product}, {3'b001, 64'd0});
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        op32(32'd6, 32'd7, 1'b0, 64'd42, 0, "post_reset");

        // WIDTH=8 random regression.
        k = 0;
        while ((pops8 < 1000 || q8_exp.size() != 0) && k < 40000) begin
            @(posedge clk); #1; k++;
            in_valid8  = (acc8 < 1000) && ($urandom_range(0, 2) != 0);
            a8         = pick8();
            b8         = pick8();
            s8         = 1'($urandom);
            out_ready8 = 1'($urandom);
        end
        in_valid8 = 1'b0;
        check("u8_results", 64'(pops8), 64'd1000);
        check("u8_leftover", 64'(q8_exp.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
